flash_word_reader: RTL and testbench
====================================

Name: flash_word_reader

Overview:
- Avalon-MM read master for the on-board flash, running in the 50 MHz domain, directly upstream of address_counter.
- Takes the word address that address_counter publishes (current_address qualified by addr_ready_flag) and fetches one 32-bit word from flash.
- Returns the word as flash_data and acknowledges with read_addr_start, which lets address_counter advance.
- addr_ready_flag and read_addr_start form a four-phase level handshake, so the 22 kHz and 50 MHz domains stay safe.

Parameters:
- ADDR_W, 23, flash word-address width.
- DATA_W, 32, flash data width.
- SYNC_STAGES, 2, flip-flop depth of the addr_ready_flag synchronizer (minimum 2).
- TIMEOUT, 255, maximum clk50M cycles spent in WAIT_DATA before the read is abandoned.

Ports:
- clk50M  in  1  50 MHz clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- addr_ready_flag  in  1  request level from address_counter (clk22K domain); current_address is stable while it is high.
- current_address  in  ADDR_W  word address to read; sampled only in the CAPTURE state.
- read_addr_start  out  1  acknowledge level; high means flash_data holds the requested word.
- flash_data  out  DATA_W  last word read; held until the next read completes.
- read_err  out  1  sticky flag; set on timeout, cleared only by reset.
- flash_mem_read  out  1  Avalon read strobe.
- flash_mem_address  out  ADDR_W  Avalon word address.
- flash_mem_byteenable  out  4  constant 4'b1111.
- flash_mem_waitrequest  in  1  Avalon slave stall.
- flash_mem_readdatavalid  in  1  Avalon read data qualifier.
- flash_mem_readdata  in  DATA_W  Avalon read data.

Behaviour:
- Reset values:
  - state = IDLE; the synchronizer chain and the edge-detect register are cleared.
  - read_addr_start, flash_mem_read, read_err = 0.
  - flash_data, flash_mem_address = 0.
- Synchronizer and edge detect:
  - addr_ready_flag passes through SYNC_STAGES flops to give req_s.
  - req_rise = req_s & ~req_s_d, using one further register req_s_d.
- FSM:
  - IDLE: on req_rise go to CAPTURE; otherwise stay. Any readdatavalid seen in IDLE is ignored, so stale responses after a reset are dropped.
  - CAPTURE: latch current_address into flash_mem_address, set flash_mem_read = 1, go to ISSUE.
  - ISSUE: hold flash_mem_read and flash_mem_address while waitrequest = 1. On the first edge with waitrequest = 0, clear flash_mem_read, clear the timeout counter and go to WAIT_DATA. Exactly one read command is accepted per request.
  - WAIT_DATA:
    - If readdatavalid = 1: flash_data <= readdata, go to ACK.
    - Else if the counter reaches TIMEOUT: flash_data <= 0, read_err <= 1, go to ACK.
    - Otherwise increment the counter.
  - ACK: read_addr_start <= 1, go to RELEASE.
  - RELEASE: hold read_addr_start = 1 until req_s = 0. Then drop read_addr_start to 0 and go to IDLE.
  - A new req_rise is only detectable after returning to IDLE, so there is no overlapping or queued request.
- Latency:
  - With zero wait states and readdatavalid one cycle after acceptance, read_addr_start rises 5 clk50M cycles after req_s rises.
  - That is roughly 7 cycles after addr_ready_flag rises (2 sync + edge + CAPTURE + ISSUE + WAIT_DATA + ACK).
  - Each waitrequest or data-delay cycle adds one cycle.
- Handshake rule: flash_data is stable from the edge that sets read_addr_start until the next ACK.
- Boundary conditions:
  - Address 0x7FFFFF is read as any other address. The block never modifies or wraps addresses; that belongs to address_counter.
  - readdatavalid asserted in the same cycle that waitrequest drops is invalid Avalon behaviour and is ignored; only WAIT_DATA samples it.
  - If addr_ready_flag falls before ACK (protocol violation), the read still completes. RELEASE then sees req_s = 0 and returns to IDLE after one cycle of read_addr_start = 1.
  - Reset mid-read: on the next edge all outputs return to reset values and flash_mem_read deasserts. In-flight data is discarded.

Test Plan:
- Basic read: flash model returns 32'hBBBBAAAA with zero wait states; current_address = 23'h000010; raise addr_ready_flag -> one read with flash_mem_address = 23'h000010, flash_data = 32'hBBBBAAAA, read_addr_start high 7 cycles after the request rises; drop addr_ready_flag -> read_addr_start low about 3 cycles later.
- Wait states: waitrequest held 4 cycles and readdatavalid 3 cycles after acceptance, data 32'hDDDDCCCC -> flash_mem_read high for exactly 5 cycles with a stable address; flash_data = 32'hDDDDCCCC; read_addr_start rises 6 cycles later than in the basic read.
- Back-to-back handshakes: addresses 0x000000, 0x000001, 0x7FFFFF issued with full four-phase cycles -> three single reads in order; each flash_data matches the model; no extra flash_mem_read pulses.
- Timeout: readdatavalid never asserts, TIMEOUT = 255 -> after 256 cycles in WAIT_DATA, flash_data = 0, read_err = 1, read_addr_start = 1; read_err stays 1 through later successful reads.
- Reset mid-read: assert reset during WAIT_DATA, then the model returns readdatavalid -> flash_data stays 0, read_addr_start stays 0, state IDLE; the next request completes normally.
- Stale request level: addr_ready_flag held high across reset deassertion -> exactly one read is issued (on the rising edge of req_s after reset), not repeated while the level stays high.

Source files
------------

// File: rtl/flash_word_reader.sv
// Avalon-MM read master: fetches one flash word per four-phase request from
// address_counter and returns it with a level acknowledge.
module flash_word_reader #(
    parameter int ADDR_W      = 23,
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic              clk50M,
    input  logic              reset,
    input  logic              addr_ready_flag,
    input  logic [ADDR_W-1:0] current_address,
    output logic              read_addr_start,
    output logic [DATA_W-1:0] flash_data,
    output logic              read_err,
    output logic              flash_mem_read,
    output logic [ADDR_W-1:0] flash_mem_address,
    output logic [3:0]        flash_mem_byteenable,
    input  logic              flash_mem_waitrequest,
    input  logic              flash_mem_readdatavalid,
    input  logic [DATA_W-1:0] flash_mem_readdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        ISSUE,
        WAIT_DATA,
        ACK,
        RELEASE
    } state_t;

    state_t              state_reg, state_next;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                req_s;
    logic                req_s_d_reg;
    logic                req_rise;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic                ack_reg, ack_next;
    logic                rd_reg, rd_next;
    logic                err_reg, err_next;
    logic [DATA_W-1:0]   data_reg, data_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;

    // addr_ready_flag comes from the 22 kHz domain; only req_s is used here.
    always_ff @(posedge clk50M) begin
        if (reset) sync_reg[0] <= 1'b0;
        else       sync_reg[0] <= addr_ready_flag;
    end

    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk50M) begin
                if (reset) sync_reg[gi] <= 1'b0;
                else       sync_reg[gi] <= sync_reg[gi-1];
            end
        end
    endgenerate

    assign req_s    = sync_reg[SYNC_STAGES-1];
    assign req_rise = req_s & ~req_s_d_reg;

    always_ff @(posedge clk50M) begin
        if (reset) begin
            state_reg   <= IDLE;
            req_s_d_reg <= 1'b0;
            cnt_reg     <= '0;
            ack_reg     <= 1'b0;
            rd_reg      <= 1'b0;
            err_reg     <= 1'b0;
            data_reg    <= '0;
            addr_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            req_s_d_reg <= req_s;
            cnt_reg     <= cnt_next;
            ack_reg     <= ack_next;
            rd_reg      <= rd_next;
            err_reg     <= err_next;
            data_reg    <= data_next;
            addr_reg    <= addr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ack_next   = ack_reg;
        rd_next    = rd_reg;
        err_next   = err_reg;
        data_next  = data_reg;
        addr_next  = addr_reg;
        case (state_reg)
            IDLE: begin
                // readdatavalid is deliberately ignored here to drop stale responses
                if (req_rise) state_next = CAPTURE;
            end
            CAPTURE: begin
                addr_next  = current_address;
                rd_next    = 1'b1;
                state_next = ISSUE;
            end
            ISSUE: begin
                if (!flash_mem_waitrequest) begin
                    rd_next    = 1'b0;
                    cnt_next   = '0;
                    state_next = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (flash_mem_readdatavalid) begin
                    data_next  = flash_mem_readdata;
                    state_next = ACK;
                end else if (cnt_reg == CNT_W'(TIMEOUT)) begin
                    data_next  = '0;
                    err_next   = 1'b1;
                    state_next = ACK;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ACK: begin
                ack_next   = 1'b1;
                state_next = RELEASE;
            end
            RELEASE: begin
                if (!req_s) begin
                    ack_next   = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign read_addr_start      = ack_reg;
    assign flash_data           = data_reg;
    assign read_err             = err_reg;
    assign flash_mem_read       = rd_reg;
    assign flash_mem_address    = addr_reg;
    assign flash_mem_byteenable = 4'b1111;

endmodule

// File: tb/tb_flash_word_reader.sv
// Randomized bench for flash_word_reader: an Avalon slave model with a sparse
// flash image, and expectations derived from request/wait/delay parameters.
module tb_flash_word_reader;

    localparam int ADDR_W  = 23;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 255;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              addr_ready_flag = 1'b0;
    logic [ADDR_W-1:0] current_address = '0;
    logic              read_addr_start;
    logic [DATA_W-1:0] flash_data;
    logic              read_err;
    logic              flash_mem_read;
    logic [ADDR_W-1:0] flash_mem_address;
    logic [3:0]        flash_mem_byteenable;
    logic              flash_mem_waitrequest = 1'b1;
    logic              flash_mem_readdatavalid = 1'b0;
    logic [DATA_W-1:0] flash_mem_readdata = '0;

    flash_word_reader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_STAGES(2), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk50M                 (clk),
        .reset                  (reset),
        .addr_ready_flag        (addr_ready_flag),
        .current_address        (current_address),
        .read_addr_start        (read_addr_start),
        .flash_data             (flash_data),
        .read_err               (read_err),
        .flash_mem_read         (flash_mem_read),
        .flash_mem_address      (flash_mem_address),
        .flash_mem_byteenable   (flash_mem_byteenable),
        .flash_mem_waitrequest  (flash_mem_waitrequest),
        .flash_mem_readdatavalid(flash_mem_readdatavalid),
        .flash_mem_readdata     (flash_mem_readdata)
    );

    always #10 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // slave configuration (written by the stimulus process)
    int              wait_cfg = 0;
    int              delay_cfg = 1;
    bit              spur_cfg = 1'b0;
    logic [ADDR_W-1:0] exp_addr = '0;
    // slave statistics (written only by the slave process)
    int              read_count = 0;
    int              hi_count = 0;
    int              addr_bad = 0;

    logic            err_exp = 1'b0;
    logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];

    function automatic logic [DATA_W-1:0] word_at(input logic [ADDR_W-1:0] a);
        if (!mem.exists(a)) mem[a] = $urandom;
        return mem[a];
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Avalon slave: drives inputs on the falling edge from the DUT's settled outputs.
    initial begin
        int wcnt;
        int pend;
        logic [ADDR_W-1:0] pa;
        wcnt = 0;
        pend = 0;
        pa   = '0;
        forever begin
            @(negedge clk);
            flash_mem_readdatavalid = 1'b0;
            flash_mem_readdata      = $urandom;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    flash_mem_readdatavalid = 1'b1;
                    flash_mem_readdata      = word_at(pa);
                end
            end
            if (flash_mem_read) begin
                hi_count++;
                if (flash_mem_address !== exp_addr) addr_bad++;
                if (wcnt < wait_cfg) begin
                    flash_mem_waitrequest = 1'b1;
                    wcnt++;
                end else begin
                    flash_mem_waitrequest = 1'b0;
                    read_count++;
                    pa   = flash_mem_address;
                    pend = delay_cfg;
                    wcnt = 0;
                    if (spur_cfg) begin
                        flash_mem_readdatavalid = 1'b1;
                        flash_mem_readdata      = 32'hDEADBEEF;
                    end
                end
            end else begin
                flash_mem_waitrequest = 1'($urandom_range(0, 1));
                wcnt = 0;
            end
        end
    end

    // One full four-phase handshake; delay == 0 means the slave never answers.
    task automatic do_read(input logic [ADDR_W-1:0] a, input int waits, input int delay, input bit spur);
        int rc0, hc0, ab0, cyc, exp_lat;
        logic [DATA_W-1:0] exp_data;
        wait_cfg = waits;
        delay_cfg = delay;
        spur_cfg = spur;
        exp_addr = a;
        current_address = a;
        exp_data = (delay == 0) ? '0 : word_at(a);
        if (delay == 0) err_exp = 1'b1;
        exp_lat = 6 + waits + ((delay == 0) ? TIMEOUT + 1 : delay);
        rc0 = read_count;
        hc0 = hi_count;
        ab0 = addr_bad;
        tick();
        addr_ready_flag = 1'b1;
        cyc = 0;
        while (!read_addr_start && cyc < exp_lat + 20) begin
            tick();
            cyc++;
        end
        $display("txn addr=%06h waits=%0d delay=%0d latency=%0d data=%08h err=%0b",
                 a, waits, delay, cyc, flash_data, read_err);
        check("latency", 64'(cyc), 64'(exp_lat));
        check("data", 64'(flash_data), 64'(exp_data));
        check("read_err", 64'(read_err), 64'(err_exp));
        check("read_cmds", 64'(read_count - rc0), 64'd1);
        check("read_hi_cycles", 64'(hi_count - hc0), 64'(waits + 1));
        check("addr_stable", 64'(addr_bad - ab0), 64'd0);
        addr_ready_flag = 1'b0;
        cyc = 0;
        while (read_addr_start && cyc < 20) begin
            tick();
            cyc++;
        end
        check("release", 64'(cyc), 64'd3);
        repeat (4) tick();
        check("no_extra_reads", 64'(read_count - rc0), 64'd1);
        check("data_hold", 64'(flash_data), 64'(exp_data));
    endtask

    initial begin
        int rc0, ack_hi, bad;
        logic [DATA_W-1:0] exp_data;

        repeat (3) tick();
        check("rst_ack", 64'(read_addr_start), 64'd0);
        check("rst_read", 64'(flash_mem_read), 64'd0);
        check("rst_err", 64'(read_err), 64'd0);
        check("rst_data", 64'(flash_data), 64'd0);
        check("rst_addr", 64'(flash_mem_address), 64'd0);
        check("byteenable", 64'(flash_mem_byteenable), 64'hF);
        reset = 1'b0;
        repeat (3) tick();

        mem[23'h000010] = 32'hBBBBAAAA;
        mem[23'h000020] = 32'hDDDDCCCC;
        do_read(23'h000010, 0, 1, 1'b0);
        do_read(23'h000020, 4, 3, 1'b0);

        do_read(23'h000000, $urandom_range(0, 3), $urandom_range(1, 4), 1'b1);
        do_read(23'h000001, $urandom_range(0, 3), $urandom_range(1, 4), 1'b0);
        do_read(23'h7FFFFF, $urandom_range(0, 3), $urandom_range(1, 4), 1'b1);

        // request withdrawn before ACK: read completes, ack lasts one cycle
        current_address = 23'h000333;
        exp_addr = 23'h000333;
        wait_cfg = 0;
        delay_cfg = 1;
        spur_cfg = 1'b0;
        exp_data = word_at(23'h000333);
        rc0 = read_count;
        addr_ready_flag = 1'b1;
        repeat (2) tick();
        addr_ready_flag = 1'b0;
        ack_hi = 0;
        repeat (20) begin
            tick();
            if (read_addr_start) ack_hi++;
        end
        check("early_drop_ack_cycles", 64'(ack_hi), 64'd1);
        check("early_drop_data", 64'(flash_data), 64'(exp_data));
        check("early_drop_reads", 64'(read_count - rc0), 64'd1);

        for (int i = 0; i < 8; i++)
            do_read(ADDR_W'($urandom), $urandom_range(0, 5), $urandom_range(1, 6), 1'($urandom_range(0, 1)));

        do_read(23'h000444, $urandom_range(0, 2), 0, 1'b0);
        do_read(23'h000555, 1, 2, 1'b0);

        // reset while waiting for data; the late response must be dropped
        current_address = 23'h000666;
        exp_addr = 23'h000666;
        wait_cfg = 0;
        delay_cfg = 15;
        spur_cfg = 1'b0;
        rc0 = read_count;
        addr_ready_flag = 1'b1;
        repeat (8) tick();
        reset = 1'b1;
        addr_ready_flag = 1'b0;
        tick();
        reset = 1'b0;
        err_exp = 1'b0;
        check("midrst_ack", 64'(read_addr_start), 64'd0);
        check("midrst_read", 64'(flash_mem_read), 64'd0);
        check("midrst_data", 64'(flash_data), 64'd0);
        check("midrst_err", 64'(read_err), 64'd0);
        check("midrst_addr", 64'(flash_mem_address), 64'd0);
        bad = 0;
        repeat (20) begin
            tick();
            if (read_addr_start || flash_data != '0) bad++;
        end
        check("midrst_stale_dropped", 64'(bad), 64'd0);
        check("midrst_reads", 64'(read_count - rc0), 64'd1);
        do_read(23'h000777, 2, 2, 1'b0);

        // request level already high when reset releases: exactly one read
        current_address = 23'h000888;
        exp_addr = 23'h000888;
        wait_cfg = 1;
        delay_cfg = 2;
        exp_data = word_at(23'h000888);
        rc0 = read_count;
        addr_ready_flag = 1'b1;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (40) tick();
        check("stale_reads", 64'(read_count - rc0), 64'd1);
        check("stale_ack", 64'(read_addr_start), 64'd1);
        check("stale_data", 64'(flash_data), 64'(exp_data));
        addr_ready_flag = 1'b0;
        repeat (6) tick();
        check("stale_release", 64'(read_addr_start), 64'd0);
        check("stale_no_extra", 64'(read_count - rc0), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
